// File: rtl/db_pkg.sv
// Shared definitions for the double-buffer controller: default depth and read-grant source encoding.
package db_pkg;

    localparam int DB_DEPTH_DEFAULT = 64;

    typedef enum logic [1:0] {
        RD_NONE = 2'd0,
        RD_TX   = 2'd1,
        RD_RX   = 2'd2
    } rd_src_t;

endpackage

// File: rtl/db_ptr_counter.sv
// Wrapping entry pointer with synchronous clear; wraps naturally at 2**ADDR_W.
module db_ptr_counter #(
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              inc,
    output logic [ADDR_W-1:0] ptr
);

    logic [ADDR_W-1:0] ptr_r;

    // Pointer register: clear wins over increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_r <= '0;
        end else if (clear) begin
            ptr_r <= '0;
        end else if (inc) begin
            ptr_r <= ptr_r + ADDR_W'(1);
        end else begin
            ptr_r <= ptr_r;
        end
    end

    assign ptr = ptr_r;

endmodule

// File: rtl/db_buffer_controller.sv
// Buffer controller: write/read arbitration, occupancy tracking and error flags.
// Define DB_STICKY_ERR_EN to make overrun_err/underrun_err latch until rst or flush.
module db_buffer_controller
    import db_pkg::*;
#(
    parameter int DEPTH  = DB_DEPTH_DEFAULT,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              store_data,
    input  logic              get_TX_packet_data,
    input  logic              get_RX_data,
    output logic [ADDR_W-1:0] w_sel,
    output logic [ADDR_W-1:0] r_sel,
    output logic              w_en,
    output logic              TX_packet_data_en,
    output logic              RX_data_en,
    output logic [ADDR_W:0]   buffer_occupancy,
    output logic              empty,
    output logic              full,
    output logic              overrun_err,
    output logic              underrun_err
);

    logic [ADDR_W-1:0] wptr_s;
    logic [ADDR_W-1:0] rptr_s;
    logic [ADDR_W:0]   occ_r;
    logic [ADDR_W:0]   occ_next_s;
    logic              empty_r;
    logic              full_r;
    logic              overrun_r;
    logic              underrun_r;
    rd_src_t           rd_src_s;
    logic              rd_s;
    logic              wr_s;
    logic              ovr_s;
    logic              und_s;

    db_ptr_counter #(.ADDR_W(ADDR_W)) u_wptr (
        .clk   (clk),
        .rst   (rst),
        .clear (flush),
        .inc   (wr_s),
        .ptr   (wptr_s)
    );

    db_ptr_counter #(.ADDR_W(ADDR_W)) u_rptr (
        .clk   (clk),
        .rst   (rst),
        .clear (flush),
        .inc   (rd_s),
        .ptr   (rptr_s)
    );

    // Grant decode, write acceptance, error detection and next occupancy.
    always_comb begin
        rd_src_s          = RD_NONE;
        TX_packet_data_en = 1'b0;
        RX_data_en        = 1'b0;
        if (!rst && !flush && !empty_r) begin
            if (get_TX_packet_data) begin
                rd_src_s = RD_TX;
            end else if (get_RX_data) begin
                rd_src_s = RD_RX;
            end else begin
                rd_src_s = RD_NONE;
            end
        end else begin
            rd_src_s = RD_NONE;
        end

        case (rd_src_s)
            RD_TX:   TX_packet_data_en = 1'b1;
            RD_RX:   RX_data_en        = 1'b1;
            default: begin
                TX_packet_data_en = 1'b0;
                RX_data_en        = 1'b0;
            end
        endcase

        rd_s = (rd_src_s != RD_NONE);
        // A full buffer still takes a write when a read frees a slot in the same cycle.
        wr_s = !rst && !flush && store_data && (!full_r || rd_s);
        w_en = wr_s;

        ovr_s = !flush && store_data && !wr_s;
        und_s = !flush && (get_TX_packet_data || get_RX_data) && empty_r;

        w_sel = wr_s ? wptr_s : '0;
        r_sel = rd_s ? rptr_s : '0;

        case ({wr_s, rd_s})
            2'b10:   occ_next_s = occ_r + (ADDR_W+1)'(1);
            2'b01:   occ_next_s = occ_r - (ADDR_W+1)'(1);
            default: occ_next_s = occ_r;
        endcase
    end

    // Occupancy, status flags and error flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ_r      <= '0;
            empty_r    <= 1'b1;
            full_r     <= 1'b0;
            overrun_r  <= 1'b0;
            underrun_r <= 1'b0;
        end else if (flush) begin
            occ_r      <= '0;
            empty_r    <= 1'b1;
            full_r     <= 1'b0;
            overrun_r  <= 1'b0;
            underrun_r <= 1'b0;
        end else begin
            occ_r   <= occ_next_s;
            empty_r <= (occ_next_s == (ADDR_W+1)'(0));
            full_r  <= (occ_next_s == (ADDR_W+1)'(DEPTH));
`ifdef DB_STICKY_ERR_EN
            overrun_r  <= overrun_r | ovr_s;
            underrun_r <= underrun_r | und_s;
`else
            overrun_r  <= ovr_s;
            underrun_r <= und_s;
`endif
        end
    end

    assign buffer_occupancy = occ_r;
    assign empty            = empty_r;
    assign full             = full_r;
    assign overrun_err      = overrun_r;
    assign underrun_err     = underrun_r;

endmodule

// File: tb/tb_db_buffer_controller.sv
// Directed self-checking bench for db_buffer_controller (DEPTH=64).
module tb_db_buffer_controller;

`ifdef DB_STICKY_ERR_EN
    localparam logic STICKY = 1'b1;
`else
    localparam logic STICKY = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic       flush;
    logic       store_data;
    logic       get_TX_packet_data;
    logic       get_RX_data;
    logic [5:0] w_sel;
    logic [5:0] r_sel;
    logic       w_en;
    logic       TX_packet_data_en;
    logic       RX_data_en;
    logic [6:0] buffer_occupancy;
    logic       empty;
    logic       full;
    logic       overrun_err;
    logic       underrun_err;

    int tests;
    int failed;

    db_buffer_controller #(.DEPTH(64)) dut (
        .clk                (clk),
        .rst                (rst),
        .flush              (flush),
        .store_data         (store_data),
        .get_TX_packet_data (get_TX_packet_data),
        .get_RX_data        (get_RX_data),
        .w_sel              (w_sel),
        .r_sel              (r_sel),
        .w_en               (w_en),
        .TX_packet_data_en  (TX_packet_data_en),
        .RX_data_en         (RX_data_en),
        .buffer_occupancy   (buffer_occupancy),
        .empty              (empty),
        .full               (full),
        .overrun_err        (overrun_err),
        .underrun_err       (underrun_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input logic s, input logic t, input logic r, input logic f);
        store_data = s; get_TX_packet_data = t; get_RX_data = r; flush = f;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b1, 1'b1, 1'b1, 1'b0);
        #1;
        tests++; if (w_en !== 1'b0) begin failed++; $display("FAIL rst_w_en: got %0b exp 0", w_en); end
        tests++; if (TX_packet_data_en !== 1'b0 || RX_data_en !== 1'b0) begin failed++; $display("FAIL rst_rd_en: got %0b%0b exp 00", TX_packet_data_en, RX_data_en); end
        tests++; if (w_sel !== 6'd0 || r_sel !== 6'd0) begin failed++; $display("FAIL rst_sel: got %0d/%0d exp 0/0", w_sel, r_sel); end
        tests++; if (buffer_occupancy !== 7'd0) begin failed++; $display("FAIL rst_occ: got %0d exp 0", buffer_occupancy); end
        tests++; if (empty !== 1'b1 || full !== 1'b0) begin failed++; $display("FAIL rst_flags: got e%0b f%0b exp e1 f0", empty, full); end
        tests++; if (overrun_err !== 1'b0 || underrun_err !== 1'b0) begin failed++; $display("FAIL rst_err: got %0b%0b exp 00", overrun_err, underrun_err); end
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        tick();
    endtask

    task automatic test_fill_overrun();
        for (int i = 0; i < 64; i++) begin
            drive(1'b1, 1'b0, 1'b0, 1'b0);
            tests++; if (w_en !== 1'b1 || w_sel !== 6'(i)) begin failed++; $display("FAIL fill_w: got en%0b sel%0d exp en1 sel%0d", w_en, w_sel, i); end
            tick();
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        tests++; if (buffer_occupancy !== 7'd64 || full !== 1'b1 || empty !== 1'b0) begin failed++; $display("FAIL fill_state: got occ%0d f%0b e%0b exp occ64 f1 e0", buffer_occupancy, full, empty); end
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        tests++; if (w_en !== 1'b0 || w_sel !== 6'd0) begin failed++; $display("FAIL ovr_w: got en%0b sel%0d exp en0 sel0", w_en, w_sel); end
        tick();
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        tests++; if (overrun_err !== 1'b1 || buffer_occupancy !== 7'd64) begin failed++; $display("FAIL ovr_flag: got err%0b occ%0d exp err1 occ64", overrun_err, buffer_occupancy); end
        tick();
        tests++; if (overrun_err !== STICKY) begin failed++; $display("FAIL ovr_pulse: got %0b exp %0b", overrun_err, STICKY); end
    endtask

    task automatic test_full_simultaneous();
        for (int i = 0; i < 65; i++) begin
            drive(1'b1, 1'b1, 1'b0, 1'b0);
            tests++; if (w_en !== 1'b1 || TX_packet_data_en !== 1'b1 || w_sel !== 6'(i % 64) || r_sel !== 6'(i % 64)) begin
                failed++; $display("FAIL full_rw: got w%0b t%0b ws%0d rs%0d exp w1 t1 ws%0d rs%0d", w_en, TX_packet_data_en, w_sel, r_sel, i % 64, i % 64);
            end
            tick();
            tests++; if (buffer_occupancy !== 7'd64 || full !== 1'b1) begin failed++; $display("FAIL full_occ: got occ%0d f%0b exp occ64 f1", buffer_occupancy, full); end
        end
        for (int k = 0; k < 64; k++) begin
            drive(1'b0, 1'b1, 1'b0, 1'b0);
            tests++; if (TX_packet_data_en !== 1'b1 || r_sel !== 6'((k + 1) % 64)) begin failed++; $display("FAIL drain: got t%0b rs%0d exp t1 rs%0d", TX_packet_data_en, r_sel, (k + 1) % 64); end
            tick();
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        tests++; if (buffer_occupancy !== 7'd0 || empty !== 1'b1 || full !== 1'b0) begin failed++; $display("FAIL drain_state: got occ%0d e%0b f%0b exp occ0 e1 f0", buffer_occupancy, empty, full); end
    endtask

    task automatic test_underrun();
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        tests++; if (RX_data_en !== 1'b0 || r_sel !== 6'd0) begin failed++; $display("FAIL und_rd: got en%0b rs%0d exp en0 rs0", RX_data_en, r_sel); end
        tick();
        drive(1'b1, 1'b0, 1'b1, 1'b0);
        tests++; if (underrun_err !== 1'b1 || buffer_occupancy !== 7'd0) begin failed++; $display("FAIL und_flag: got err%0b occ%0d exp err1 occ0", underrun_err, buffer_occupancy); end
        tests++; if (w_en !== 1'b1 || w_sel !== 6'd1 || RX_data_en !== 1'b0) begin failed++; $display("FAIL und_bypass: got w%0b ws%0d r%0b exp w1 ws1 r0", w_en, w_sel, RX_data_en); end
        tick();
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        tests++; if (underrun_err !== 1'b1 || buffer_occupancy !== 7'd1) begin failed++; $display("FAIL und_flag2: got err%0b occ%0d exp err1 occ1", underrun_err, buffer_occupancy); end
        for (int i = 0; i < 5; i++) tick();
        tests++; if (underrun_err !== STICKY) begin failed++; $display("FAIL und_hold: got %0b exp %0b", underrun_err, STICKY); end
    endtask

    task automatic test_flush();
        for (int i = 0; i < 9; i++) begin
            drive(1'b1, 1'b0, 1'b0, 1'b0);
            tick();
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        tests++; if (buffer_occupancy !== 7'd10) begin failed++; $display("FAIL pre_flush: got %0d exp 10", buffer_occupancy); end
        drive(1'b1, 1'b1, 1'b0, 1'b1);
        tests++; if (w_en !== 1'b0 || TX_packet_data_en !== 1'b0) begin failed++; $display("FAIL flush_en: got w%0b t%0b exp w0 t0", w_en, TX_packet_data_en); end
        tick();
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        tests++; if (buffer_occupancy !== 7'd0 || empty !== 1'b1) begin failed++; $display("FAIL flush_state: got occ%0d e%0b exp occ0 e1", buffer_occupancy, empty); end
        tests++; if (overrun_err !== 1'b0 || underrun_err !== 1'b0) begin failed++; $display("FAIL flush_err: got %0b%0b exp 00", overrun_err, underrun_err); end
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        tests++; if (w_en !== 1'b1 || w_sel !== 6'd0) begin failed++; $display("FAIL flush_wsel: got en%0b sel%0d exp en1 sel0", w_en, w_sel); end
        tick();
    endtask

    task automatic test_priority();
        for (int i = 1; i < 3; i++) begin
            drive(1'b1, 1'b0, 1'b0, 1'b0);
            tests++; if (w_sel !== 6'(i)) begin failed++; $display("FAIL prio_fill: got %0d exp %0d", w_sel, i); end
            tick();
        end
        drive(1'b0, 1'b1, 1'b1, 1'b0);
        tests++; if (TX_packet_data_en !== 1'b1 || RX_data_en !== 1'b0 || r_sel !== 6'd0) begin failed++; $display("FAIL prio_grant: got t%0b r%0b rs%0d exp t1 r0 rs0", TX_packet_data_en, RX_data_en, r_sel); end
        tick();
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        tests++; if (buffer_occupancy !== 7'd2 || underrun_err !== 1'b0) begin failed++; $display("FAIL prio_occ: got occ%0d u%0b exp occ2 u0", buffer_occupancy, underrun_err); end
        tests++; if (RX_data_en !== 1'b1 || r_sel !== 6'd1) begin failed++; $display("FAIL rx_grant: got r%0b rs%0d exp r1 rs1", RX_data_en, r_sel); end
        tick();
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        tests++; if (buffer_occupancy !== 7'd1) begin failed++; $display("FAIL rx_occ: got %0d exp 1", buffer_occupancy); end
    endtask

    task automatic test_reset_mid();
        store_data = 1'b1;
        rst = 1'b1;
        #1;
        tests++; if (buffer_occupancy !== 7'd0 || empty !== 1'b1 || w_en !== 1'b0) begin failed++; $display("FAIL mid_rst: got occ%0d e%0b w%0b exp occ0 e1 w0", buffer_occupancy, empty, w_en); end
        #1;
        rst = 1'b0;
        #1;
        tests++; if (w_en !== 1'b1 || w_sel !== 6'd0) begin failed++; $display("FAIL post_rst_w: got en%0b sel%0d exp en1 sel0", w_en, w_sel); end
        tick();
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        tests++; if (buffer_occupancy !== 7'd1) begin failed++; $display("FAIL post_rst_occ: got %0d exp 1", buffer_occupancy); end
    endtask

    initial begin
        tests = 0;
        failed = 0;
        rst = 1'b1;
        flush = 1'b0;
        store_data = 1'b0;
        get_TX_packet_data = 1'b0;
        get_RX_data = 1'b0;
        test_reset();
        test_fill_overrun();
        test_full_simultaneous();
        test_underrun();
        test_flush();
        test_priority();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
